lfsr_stream_gen: RTL and testbench
==================================

Name: lfsr_stream_gen

Overview:
Parametrised LFSR pseudo-random word generator, the successor to the fixed 32-bit free-running LFSR.
- Configurable width, taps, seed and polynomial form (Fibonacci or Galois).
- Advances STEP bits per produced word, with runtime seed loading and zero-seed protection.
- Output is a registered valid/ready stream with a word counter, so it can feed test-pattern, scrambler or dither consumers that may stall.

Parameters:
WIDTH, 32, state/output width in bits (4..64)
TAPS, 32'h80200003, feedback mask, WIDTH bits
SEED, 1, reset/recovery state; must be non-zero
MODE, 0, 0 = Fibonacci, 1 = Galois
STEP, 1, LFSR single-steps applied per produced word (1..WIDTH)
CNT_W, 16, width of word counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  generation enable
seed_load  in  1  load seed_val into state this cycle
seed_val  in  WIDTH  runtime seed
out_ready  in  1  consumer accepts out_data
out_valid  out  1  out_data holds a valid word
out_data  out  WIDTH  generated word
word_cnt  out  CNT_W  count of accepted words (wraps)
seed_err  out  1  sticky: a zero seed was loaded

Behaviour:
- Reset (async on rst_n low):
  - state = SEED, out_valid = 0, out_data = 0, word_cnt = 0, seed_err = 0.
- Single step f(s):
  - Fibonacci: f(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
  - Galois: f(s) = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1).
- next = f applied STEP times; it is combinational, unrolled in one cycle.
- Word production:
  - Define `load_slot = !out_valid || out_ready`.
  - If en && load_slot: state <= next, out_data <= next, out_valid <= 1.
  - Latency is 1 cycle from slot open to valid.
  - out_data is stable while out_valid && !out_ready; state does not advance while stalled.
  - If !en && out_valid && out_ready: out_valid <= 0, state is held.
  - If !en and no handshake: everything is held.
- Handshake: word_cnt += 1 (mod 2^CNT_W) on every cycle with out_valid && out_ready.
- Seed load has priority over production:
  - State: state <= seed_val, or SEED if seed_val == 0.
  - Flag: seed_err <= 1 if seed_val == 0; the flag is sticky until reset.
  - Output: out_valid <= 0 (the pending word is flushed); out_data is held.
  - Counter: word_cnt increments if a handshake occurs in the same cycle, because the consumer took the word.
  - The first post-load word appears 1 cycle after the next cycle with en && load_slot.
- Zero state is never reachable: SEED is non-zero, zero loads are substituted, and f maps non-zero to non-zero for valid tap masks.
- Period: for a primitive TAPS the sequence repeats after 2^WIDTH-1 single steps; this is the user's responsibility.
- Reset mid-stall: the output is dropped immediately; no word is replayed.
- Elaboration checks (fail via generate error):
  - SEED == 0
  - STEP == 0 or STEP > WIDTH
  - MODE not in {0, 1}

Decomposition:
- Package lfsr_pkg:
  - MODE_FIB/MODE_GAL constants.
  - Default TAPS constants for widths 8/16/24/32/64.
  - A function lfsr_step(state, taps, mode) used by both RTL and bench model.
- Sub-module lfsr_stepper: combinational, STEP-times unroll of lfsr_step with parameters WIDTH/TAPS/MODE/STEP.
- The top module holds the state register, output buffer, counter and seed logic.

Test Plan:
- WIDTH=32, TAPS=32'h80200003, SEED=1, MODE=0, STEP=1; rst_n low then high, en=1, out_ready=1 -> out_data sequence 0x00000003, 0x00000006, 0x0000000D; word_cnt 1, 2, 3.
- Same configuration with STEP=4 -> first word 0x0000001B.
- MODE=1, STEP=1, SEED=1 -> words 0x80200003, then 0xC0300002.
- Backpressure: out_ready=0 for 5 cycles after the first word -> out_data stays 0x00000003, out_valid stays 1, word_cnt stays 0. Raise out_ready -> next word is 0x00000006.
- seed_load with seed_val=0x00000003 while a word is pending -> out_valid drops next cycle, then the next word is 0x00000006. seed_load with seed_val=0 -> seed_err=1 and the state restarts from SEED, so the next word is 0x00000003.
- Counter wrap with CNT_W=2 -> after 5 accepted words word_cnt=1. Async rst_n pulse mid-stream -> outputs are at reset values within the same cycle, and the sequence restarts at 0x00000003.

Source files
------------

// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg : shared LFSR constants and the single-step function
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  localparam logic [7:0]  c_TAPS_8  = 8'hB8;
  localparam logic [15:0] c_TAPS_16 = 16'hB400;
  localparam logic [23:0] c_TAPS_24 = 24'hE10000;
  localparam logic [31:0] c_TAPS_32 = 32'h80200003;
  localparam logic [63:0] c_TAPS_64 = 64'hD800000000000000;

  // Operates on a 64-bit container; bits at or above width must be zero on entry.
  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int          mode,
                                            input int          width);
    logic [63:0] w_mask;
    logic [63:0] w_res;
    w_mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (mode == MODE_GAL) begin
      w_res = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    end else begin
      w_res = ((state << 1) | {63'd0, ^(state & taps)}) & w_mask;
    end
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_stepper.sv
// ---------------------------------------------------------------------------
// lfsr_stepper : combinational STEP-times unroll of lfsr_step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_stepper
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
  parameter int               MODE  = 0,
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] w_chain [0:STEP];

  assign w_chain[0] = i_state;

  for (genvar k = 0; k < STEP; k++) begin : g_step
    assign w_chain[k+1] = WIDTH'(lfsr_step(64'(w_chain[k]), 64'(TAPS), MODE, WIDTH));
  end

  assign o_next = w_chain[STEP];

endmodule

`default_nettype wire

// File: rtl/lfsr_stream_gen.sv
// ---------------------------------------------------------------------------
// lfsr_stream_gen : parametrised LFSR word generator with valid/ready output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               MODE  = 0,
  parameter int               STEP  = 1,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seed_err
);

  if (SEED == '0) begin : g_err_seed
    $error("lfsr_stream_gen: SEED must be non-zero");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_err_step
    $error("lfsr_stream_gen: STEP must be in 1..WIDTH");
  end
  if (MODE != MODE_FIB && MODE != MODE_GAL) begin : g_err_mode
    $error("lfsr_stream_gen: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_next;
  logic             w_slot;
  logic             w_hs;
  logic             w_seed_zero;

  lfsr_stepper #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE),
    .STEP  (STEP)
  ) u_stepper (
    .i_state (r_state),
    .o_next  (w_next)
  );

  assign w_slot      = !r_valid || out_ready;
  assign w_hs        = r_valid && out_ready;
  assign w_seed_zero = (seed_val == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A seed load flushes any pending word; a zero seed falls back to SEED.
      if (seed_load) begin
        r_state <= w_seed_zero ? SEED : seed_val;
        r_valid <= 1'b0;
        if (w_seed_zero) begin
          r_err <= 1'b1;
        end
      end else if (en && w_slot) begin
        r_state <= w_next;
        r_data  <= w_next;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign word_cnt  = r_cnt;
  assign seed_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_gen : four configurations driven in parallel against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lfsr_stream_gen;

  localparam logic [31:0] c_TAPS = 32'h80200003;
  localparam int          c_N    = 4;

  // Instance 0: Fibonacci STEP=1; 1: Fibonacci STEP=4; 2: Galois STEP=1; 3: CNT_W=2
  function automatic int cfg_mode(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_step(input int i);
    return (i == 1) ? 4 : 1;
  endfunction
  function automatic int cfg_cntw(input int i);
    return (i == 3) ? 2 : 16;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [31:0] seed_val;
  logic        out_ready;

  logic        v [c_N];
  logic [31:0] d [c_N];
  logic        e [c_N];
  logic [15:0] c0, c1, c2;
  logic [1:0]  c3;
  logic [15:0] cnt [c_N];

  assign cnt[0] = c0;
  assign cnt[1] = c1;
  assign cnt[2] = c2;
  assign cnt[3] = {14'd0, c3};

  always #5 clk = ~clk;

  lfsr_stream_gen #(.WIDTH(32), .TAPS(c_TAPS), .SEED(32'd1), .MODE(0), .STEP(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .out_ready(out_ready), .out_valid(v[0]), .out_data(d[0]), .word_cnt(c0), .seed_err(e[0]));
  lfsr_stream_gen #(.WIDTH(32), .TAPS(c_TAPS), .SEED(32'd1), .MODE(0), .STEP(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .out_ready(out_ready), .out_valid(v[1]), .out_data(d[1]), .word_cnt(c1), .seed_err(e[1]));
  lfsr_stream_gen #(.WIDTH(32), .TAPS(c_TAPS), .SEED(32'd1), .MODE(1), .STEP(1), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .out_ready(out_ready), .out_valid(v[2]), .out_data(d[2]), .word_cnt(c2), .seed_err(e[2]));
  lfsr_stream_gen #(.WIDTH(32), .TAPS(c_TAPS), .SEED(32'd1), .MODE(0), .STEP(1), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_val(seed_val),
    .out_ready(out_ready), .out_valid(v[3]), .out_data(d[3]), .word_cnt(c3), .seed_err(e[3]));

  // Reference: Fibonacci feeds back the tap parity; Galois xors taps when a 1 shifts out.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input int mode);
    if (mode == 0) begin
      return (s << 1) | 32'($countones(s & c_TAPS) % 2);
    end
    return (s >> 1) ^ (s[0] ? c_TAPS : 32'd0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] s, input int i);
    logic [31:0] t;
    t = s;
    for (int k = 0; k < cfg_step(i); k++) begin
      t = ref_step(t, cfg_mode(i));
    end
    return t;
  endfunction

  logic [31:0] m_state [c_N];
  logic [31:0] m_data  [c_N];
  logic        m_valid [c_N];
  logic        m_err   [c_N];
  int unsigned m_cnt   [c_N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_N; i++) begin
        m_state[i] <= 32'd1;
        m_data[i]  <= 32'd0;
        m_valid[i] <= 1'b0;
        m_err[i]   <= 1'b0;
        m_cnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < c_N; i++) begin
        if (m_valid[i] && out_ready) begin
          m_cnt[i] <= (m_cnt[i] + 1) % (1 << cfg_cntw(i));
        end
        if (seed_load) begin
          m_state[i] <= (seed_val == 32'd0) ? 32'd1 : seed_val;
          m_valid[i] <= 1'b0;
          if (seed_val == 32'd0) m_err[i] <= 1'b1;
        end else if (en && (!m_valid[i] || out_ready)) begin
          m_state[i] <= ref_word(m_state[i], i);
          m_data[i]  <= ref_word(m_state[i], i);
          m_valid[i] <= 1'b1;
        end else if (m_valid[i] && out_ready) begin
          m_valid[i] <= 1'b0;
        end
      end
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < c_N; i++) begin
      check($sformatf("valid%0d", i), 64'(v[i]),   64'(m_valid[i]));
      check($sformatf("data%0d", i),  64'(d[i]),   64'(m_data[i]));
      check($sformatf("cnt%0d", i),   64'(cnt[i]), 64'(m_cnt[i]));
      check($sformatf("err%0d", i),   64'(e[i]),   64'(m_err[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(v[0]), 64'd0);
    check("rst_async_data",  64'(d[0]), 64'd0);
    check("rst_async_cnt",   64'(c0),   64'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    seed_load = 1'b0;
    seed_val  = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(v[0]), 64'd0);
    check("rst_data",  64'(d[0]), 64'd0);
    check("rst_cnt",   64'(c0),   64'd0);
    check("rst_err",   64'(e[0]), 64'd0);
    check_model();

    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick();
    check("fib_w1",  64'(d[0]), 64'h3);
    check("step4_w1", 64'(d[1]), 64'h1B);
    check("gal_w1",  64'(d[2]), 64'h80200003);

    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("stall_data",  64'(d[0]), 64'h3);
      check("stall_valid", 64'(v[0]), 64'd1);
      check("stall_cnt",   64'(c0),   64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("fib_w2", 64'(d[0]), 64'h6);
    check("cnt_w2", 64'(c0),   64'd1);
    check("gal_w2", 64'(d[2]), 64'hC0300002);
    tick();
    check("fib_w3", 64'(d[0]), 64'hD);
    check("cnt_w3", 64'(c0),   64'd2);

    out_ready = 1'b0; seed_load = 1'b1; seed_val = 32'h3;
    tick();
    check("load_flush_valid", 64'(v[0]), 64'd0);
    check("load_hold_data",   64'(d[0]), 64'hD);
    seed_load = 1'b0; out_ready = 1'b1;
    tick();
    check("load_word", 64'(d[0]), 64'h6);
    seed_load = 1'b1; seed_val = 32'h0;
    tick();
    check("zero_err",   64'(e[0]), 64'd1);
    check("zero_valid", 64'(v[0]), 64'd0);
    check("zero_cnt",   64'(c0),   64'd3);
    seed_load = 1'b0;
    tick();
    check("zero_restart", 64'(d[0]), 64'h3);

    en = 1'b0;
    repeat (2) tick();
    check("disabled_drain", 64'(v[0]), 64'd0);
    en = 1'b1;

    async_reset();
    tick();
    check("post_rst_w1", 64'(d[0]), 64'h3);
    repeat (5) tick();
    check("cnt_wrap", 64'(c3), 64'd1);

    for (int n = 0; n < 500; n++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      seed_load = ($urandom_range(0, 19) == 0);
      seed_val  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
